// File: rtl/polcordic.sv
// polcordic: pipelined rotation-mode CORDIC, polar (Mag, Ang) to cartesian (X, Y)
//   clk, rst (async, active high)
//   in_valid, Mag[16:0] (clamped to 0x0FFFF), Ang[16:0] (1 LSB = 1/256 deg)
//   out_valid, X = Mag*cos(Ang), Y = Mag*sin(Ang), both 17-bit two's complement
module polcordic #(
  parameter int ITERATIONS = 12,
  parameter int GW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [16:0] Mag,
  input  logic [16:0] Ang,
  output logic        out_valid,
  output logic [16:0] X,
  output logic [16:0] Y
);
  localparam int N = ITERATIONS;
  localparam int W = 17 + GW;
  localparam logic signed [W-1:0] SMAX = W'(65535);
  localparam logic signed [17:0] ATAN [16] = '{
    18'sd11520, 18'sd6801, 18'sd3593, 18'sd1824, 18'sd916, 18'sd458, 18'sd229, 18'sd115,
    18'sd57, 18'sd29, 18'sd14, 18'sd7, 18'sd4, 18'sd2, 18'sd1, 18'sd0};
  logic signed [W-1:0] xs [0:N];
  logic signed [W-1:0] ys [0:N];
  logic signed [17:0]  zs [0:N];
  logic [1:0]          qs [0:N];
  logic                vs [0:N];
  logic [15:0]         mag_c;
  logic [16:0]         a;
  logic [1:0]          q0;
  logic signed [W-1:0] xr, yr;
  function automatic logic [16:0] sat(input logic signed [W-1:0] v);
    return v > SMAX ? 17'h0FFFF : v < -SMAX ? 17'h10001 : v[16:0];
  endfunction
  always_comb begin
    mag_c = Mag[16] ? 16'hFFFF : Mag[15:0];
    a     = Ang >= 17'h16800 ? Ang - 17'h16800 : Ang;
    q0    = a < 17'h05A00 ? 2'd0 : a < 17'h0B400 ? 2'd1 : a < 17'h10E00 ? 2'd2 : 2'd3;
    xr    = qs[N] == 2'd0 ? xs[N] : qs[N] == 2'd1 ? -ys[N] : qs[N] == 2'd2 ? -xs[N] : ys[N];
    yr    = qs[N] == 2'd0 ? ys[N] : qs[N] == 2'd1 ? xs[N] : qs[N] == 2'd2 ? -ys[N] : -xs[N];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i <= N; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        zs[i] <= '0;
        qs[i] <= '0;
        vs[i] <= 1'b0;
      end
      out_valid <= 1'b0;
      X         <= '0;
      Y         <= '0;
    end else begin
      vs[0] <= in_valid;
      xs[0] <= W'((32'(mag_c) * 32'd19898) >> 15);
      ys[0] <= '0;
      zs[0] <= 18'(a) - 18'(q0) * 18'h05A00;
      qs[0] <= q0;
      for (int i = 0; i < N; i++) begin
        xs[i+1] <= zs[i][17] ? xs[i] + (ys[i] >>> i) : xs[i] - (ys[i] >>> i);
        ys[i+1] <= zs[i][17] ? ys[i] - (xs[i] >>> i) : ys[i] + (xs[i] >>> i);
        zs[i+1] <= zs[i][17] ? zs[i] + ATAN[i] : zs[i] - ATAN[i];
        qs[i+1] <= qs[i];
        vs[i+1] <= vs[i];
      end
      out_valid <= vs[N];
      X         <= sat(xr);
      Y         <= sat(yr);
    end
endmodule

// File: tb/tb_polcordic.sv
// tb_polcordic: directed-vector bench for polcordic against a real-number model
module tb_polcordic;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [16:0] Mag = '0;
  logic [16:0] Ang = '0;
  logic        out_valid;
  logic [16:0] X, Y;
  typedef struct {int x; int y; int tol;} exp_t;
  exp_t        mem [256];
  exp_t        e;
  logic [7:0]  wr = '0;
  logic [7:0]  rd = '0;
  bit   [13:0] vh = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          m;
  real         th;
  polcordic dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Mag(Mag), .Ang(Ang),
    .out_valid(out_valid), .X(X), .Y(Y)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp, input int tol);
    n_vec++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask
  task automatic send(input logic [16:0] mg, input logic [16:0] an);
    in_valid = 1'b1;
    Mag = mg;
    Ang = an;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) vh <= '0;
    else begin
      vh <= {vh[12:0], in_valid};
      if (in_valid) begin
        m  = Mag > 17'h0FFFF ? 65535 : int'(Mag);
        th = real'(Ang) * 3.14159265358979 / (180.0 * 256.0);
        mem[wr] <= '{int'(m * $cos(th)), int'(m * $sin(th)), m == 0 ? 0 : m / 2048 + 6};
        wr <= wr + 8'd1;
      end
    end
  always @(negedge clk) begin
    check("valid", int'(out_valid), int'(vh[13]), 0);
    if (rst) rd <= wr;
    else if (out_valid) begin
      if (rd == wr) check("spurious", 1, 0, 0);
      else begin
        e = mem[rd];
        check("X", int'($signed(X)), e.x, e.tol);
        check("Y", int'($signed(Y)), e.y, e.tol);
        rd <= rd + 8'd1;
      end
    end
  end
  initial begin
    logic [16:0] vm [14] = '{17'h08000, 17'h08000, 17'h08000, 17'h08000, 17'h08000, 17'h08000, 17'h08000,
                             17'h08000, 17'h0FFFF, 17'h1FFFF, 17'h00000, 17'h1FFFF, 17'h1FFFF, 17'h04000};
    logic [16:0] va [14] = '{17'h05A00, 17'h0B400, 17'h10E00, 17'h16800, 17'h00001, 17'h16801, 17'h1FFFF,
                             17'h097FF, 17'h02D00, 17'h02D00, 17'h03000, 17'h00000, 17'h0B400, 17'h0E000};
    idle(2);
    check("rst_valid", int'(out_valid), 0, 0);
    check("rst_X", int'(X), 0, 0);
    check("rst_Y", int'(Y), 0, 0);
    rst = 1'b0;
    send(17'h08000, 17'h00000);
    idle(20);
    for (int k = 0; k < 14; k++) begin
      send(vm[k], va[k]);
      if (k % 3 == 2) idle(2);
    end
    idle(20);
    for (int k = 0; k < 18; k++) send(vm[k % 14], va[k % 14]);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0, 0);
    check("mid_rst_X", int'(X), 0, 0);
    check("mid_rst_Y", int'(Y), 0, 0);
    in_valid = 1'b1;
    idle(2);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(5);
    send(17'h08000, 17'h05A00);
    idle(20);
    check("drain", int'(wr - rd), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
